// File: rtl/trace_stream_mux.sv
// rtl/trace_stream_mux.sv - multi-channel trace arbiter, FIFO and hex/binary byte serialiser
// Round-robin arbitrates per-core retire beats into a shared FIFO and streams each entry as bytes.
module trace_stream_mux #(
  parameter int NCH          = 2,
  parameter int PC_W         = 64,
  parameter int INST_W       = 32,
  parameter int DEPTH        = 4096,
  parameter int HEX_MODE     = 1,
  parameter int DROP_ON_FULL = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NCH-1:0]            in_valid,
  input  logic [NCH*PC_W-1:0]       in_pc,
  input  logic [NCH*INST_W-1:0]     in_inst,
  output logic [NCH-1:0]            in_ready,
  output logic                      tx_valid,
  output logic [7:0]                tx_data,
  input  logic                      tx_ready,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic [31:0]               drop_cnt
);

  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW  = $clog2(DEPTH);
  localparam int EW  = CW + PC_W + INST_W;
  localparam int CH  = (CW + 3) / 4;
  localparam int PCD = PC_W / 4;
  localparam int ID  = INST_W / 4;
  localparam int NB  = (HEX_MODE != 0) ? (CH + PCD + ID + 3) : (1 + PC_W / 8 + INST_W / 8);
  localparam int IW  = $clog2(NB);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} state_t;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  // Byte i of the serialised line for entry e.
  function automatic logic [7:0] byte_at(input logic [EW-1:0] e, input int i);
    logic [CW+3:0]     sc;
    logic [PC_W+7:0]   sp;
    logic [INST_W+7:0] si;
    logic [7:0]        b;
    sc = {4'h0, e[EW-1 -: CW]};
    sp = {8'h00, e[INST_W +: PC_W]};
    si = {8'h00, e[INST_W-1:0]};
    b  = 8'h00;
    if (HEX_MODE != 0) begin
      if (i < CH) begin
        sc = sc >> (4 * (CH - 1 - i));
        b  = hex_char(sc[3:0]);
      end else if (i == CH || i == CH + PCD + 1) begin
        b = 8'h20;
      end else if (i <= CH + PCD) begin
        sp = sp >> (4 * (CH + PCD - i));
        b  = hex_char(sp[3:0]);
      end else if (i < NB - 1) begin
        si = si >> (4 * (NB - 2 - i));
        b  = hex_char(si[3:0]);
      end else begin
        b = 8'h0a;
      end
    end else begin
      if (i == 0) begin
        b = 8'(sc[CW-1:0]);
      end else if (i <= PC_W / 8) begin
        sp = sp >> (8 * (i - 1));
        b  = sp[7:0];
      end else begin
        si = si >> (8 * (i - 1 - PC_W / 8));
        b  = si[7:0];
      end
    end
    return b;
  endfunction

  logic [CW-1:0]   r_rr;
  logic [AW-1:0]   r_wp, r_rp;
  logic [AW:0]     r_level;
  logic [31:0]     r_drop;
  logic [EW-1:0]   r_mem [DEPTH];
  logic [EW-1:0]   r_ram_q;
  logic [EW-1:0]   r_line;
  logic [IW-1:0]   r_idx;
  logic            r_tx_valid;
  logic [7:0]      r_tx_data;
  state_t          r_state;

  logic [CW-1:0]   w_grant, w_rr_next;
  logic            w_found, w_full, w_push, w_pop;
  logic [NCH-1:0]  w_ready;
  logic [PC_W-1:0] w_pc;
  logic [INST_W-1:0] w_inst;
  logic [EW-1:0]   w_wdata;
  logic [5:0]      w_nvalid, w_ndrop;
  logic [32:0]     w_sum;

  // Pick the valid channel closest to r_rr going upward with wrap.
  always_comb begin
    int best;
    int d;
    int nx;
    w_found  = 1'b0;
    w_grant  = '0;
    best     = NCH;
    w_nvalid = '0;
    for (int i = 0; i < NCH; i++) begin
      d = i - int'(r_rr);
      if (d < 0) d = d + NCH;
      if (in_valid[i] && d < best) begin
        best    = d;
        w_grant = CW'(i);
        w_found = 1'b1;
      end
      w_nvalid = w_nvalid + {5'b0, in_valid[i]};
    end
    nx = int'(w_grant) + 1;
    if (nx >= NCH) nx = 0;
    w_rr_next = CW'(nx);
  end

  always_comb begin
    w_pc   = '0;
    w_inst = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_grant == CW'(i)) begin
        w_pc   = in_pc[i*PC_W +: PC_W];
        w_inst = in_inst[i*INST_W +: INST_W];
      end
    end
  end

  assign w_full  = (r_level == (AW+1)'(DEPTH));
  assign w_push  = w_found && !w_full;
  assign w_pop   = (r_state == S_IDLE) && (r_level != '0);
  assign w_wdata = {w_grant, w_pc, w_inst};
  assign w_ndrop = w_nvalid - {5'b0, w_push};
  assign w_sum   = {1'b0, r_drop} + {27'b0, w_ndrop};

  always_comb begin
    w_ready = '0;
    for (int i = 0; i < NCH; i++) begin
      w_ready[i] = (DROP_ON_FULL != 0) ? 1'b1 : (!w_full && w_found && w_grant == CW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= w_wdata;
    if (w_pop)  r_ram_q     <= r_mem[r_rp];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
      r_rr    <= '0;
      r_drop  <= '0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + AW'(1);
        r_rr <= w_rr_next;
      end
      if (w_pop) r_rp <= r_rp + AW'(1);
      if (w_push && !w_pop)      r_level <= r_level + (AW+1)'(1);
      else if (!w_push && w_pop) r_level <= r_level - (AW+1)'(1);
      if (DROP_ON_FULL != 0) r_drop <= w_sum[32] ? 32'hffff_ffff : w_sum[31:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_line     <= '0;
      r_idx      <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: if (w_pop) r_state <= S_LOAD;
        S_LOAD: begin
          r_line     <= r_ram_q;
          r_idx      <= '0;
          r_tx_valid <= 1'b1;
          r_tx_data  <= byte_at(r_ram_q, 0);
          r_state    <= S_SEND;
        end
        S_SEND: begin
          if (tx_ready) begin
            if (r_idx == IW'(NB - 1)) begin
              r_tx_valid <= 1'b0;
              r_tx_data  <= 8'h00;
              r_state    <= S_IDLE;
            end else begin
              r_idx     <= r_idx + IW'(1);
              r_tx_data <= byte_at(r_line, int'(r_idx) + 1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = rst ? '0 : w_ready;
  assign tx_valid   = r_tx_valid;
  assign tx_data    = r_tx_data;
  assign fifo_level = r_level;
  assign drop_cnt   = r_drop;

endmodule

// File: tb/tb_trace_stream_mux.sv
// tb/tb_trace_stream_mux.sv - randomized/directed bench for trace_stream_mux against a queue-based model
module tb_trace_stream_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  int          sel;
  logic [2:0]  t_valid;
  logic [63:0] t_pc [3];
  logic [31:0] t_inst [3];
  logic        t_txr;

  logic [1:0]   a_valid, a_ready;
  logic [127:0] a_pc;
  logic [63:0]  a_inst;
  logic         a_txv, a_txr;
  logic [7:0]   a_txd;
  logic [4:0]   a_lvl;
  logic [31:0]  a_drop;

  logic [2:0]   b_valid, b_ready;
  logic [191:0] b_pc;
  logic [95:0]  b_inst;
  logic         b_txv, b_txr;
  logic [7:0]   b_txd;
  logic [4:0]   b_lvl;
  logic [31:0]  b_drop;

  assign a_valid = (sel == 0) ? t_valid[1:0] : 2'b00;
  assign a_pc    = {t_pc[1], t_pc[0]};
  assign a_inst  = {t_inst[1], t_inst[0]};
  assign a_txr   = (sel == 0) && t_txr;
  assign b_valid = (sel == 1) ? t_valid : 3'b000;
  assign b_pc    = {t_pc[2], t_pc[1], t_pc[0]};
  assign b_inst  = {t_inst[2], t_inst[1], t_inst[0]};
  assign b_txr   = (sel == 1) && t_txr;

  trace_stream_mux #(.NCH(2), .PC_W(64), .INST_W(32), .DEPTH(16), .HEX_MODE(1), .DROP_ON_FULL(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_pc(a_pc), .in_inst(a_inst), .in_ready(a_ready),
    .tx_valid(a_txv), .tx_data(a_txd), .tx_ready(a_txr), .fifo_level(a_lvl), .drop_cnt(a_drop));

  trace_stream_mux #(.NCH(3), .PC_W(64), .INST_W(32), .DEPTH(16), .HEX_MODE(0), .DROP_ON_FULL(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_pc(b_pc), .in_inst(b_inst), .in_ready(b_ready),
    .tx_valid(b_txv), .tx_data(b_txd), .tx_ready(b_txr), .fifo_level(b_lvl), .drop_cnt(b_drop));

  typedef struct {
    int          ch;
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        m_fifo[$];
  ent_t        m_held;
  bit          m_loadp;
  logic [7:0]  m_line[$];
  int          m_rr;
  longint      m_drop;
  logic [7:0]  cap[$];
  int          nvec = 0;
  int          nfail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_str(input string tag, input string obs, input string exp);
    nvec++;
    assert (obs == exp) else begin
      nfail++;
      $error("FAIL %s: observed [%s] expected [%s]", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_line.delete();
    m_loadp = 1'b0;
    m_rr    = 0;
    m_drop  = 0;
  endtask

  task automatic render(input ent_t e);
    string      s;
    logic [3:0] c4;
    logic [63:0] p;
    logic [31:0] n;
    if (sel == 0) begin
      c4 = 4'(e.ch);
      s  = $sformatf("%h %h %h\n", c4, e.pc, e.inst);
      for (int k = 0; k < s.len(); k++) m_line.push_back(s[k]);
    end else begin
      p = e.pc;
      n = e.inst;
      m_line.push_back(8'(e.ch));
      for (int k = 0; k < 8; k++) m_line.push_back(p[8*k +: 8]);
      for (int k = 0; k < 4; k++) m_line.push_back(n[8*k +: 8]);
    end
  endtask

  // Compare all outputs with the model, then advance the model across one clock edge.
  task automatic tick();
    logic [2:0]  o_rdy, mask, exp_rdy;
    logic        o_txv;
    logic [7:0]  o_txd;
    logic [4:0]  o_lvl;
    logic [31:0] o_drop;
    int          nch, lvl, best, g, nv;
    bit          full, found, push, idle;
    ent_t        e;
    #1;
    nch    = (sel == 0) ? 2 : 3;
    mask   = (sel == 0) ? 3'b011 : 3'b111;
    o_rdy  = (sel == 0) ? {1'b0, a_ready} : b_ready;
    o_txv  = (sel == 0) ? a_txv : b_txv;
    o_txd  = (sel == 0) ? a_txd : b_txd;
    o_lvl  = (sel == 0) ? a_lvl : b_lvl;
    o_drop = (sel == 0) ? a_drop : b_drop;
    lvl    = m_fifo.size();
    full   = (lvl == 16);
    found  = 1'b0;
    best   = 99;
    g      = 0;
    nv     = 0;
    for (int i = 0; i < nch; i++) begin
      if (t_valid[i]) begin
        int d;
        d = (i - m_rr + nch) % nch;
        nv++;
        if (d < best) begin
          best  = d;
          g     = i;
          found = 1'b1;
        end
      end
    end
    push = found && !full;
    if (sel == 1) begin
      chk("in_ready_drop", o_rdy, mask);
    end else begin
      exp_rdy = push ? (3'b001 << g) : 3'b000;
      chk("in_ready_grant", o_rdy & t_valid & mask, exp_rdy);
    end
    chk("tx_valid", o_txv, m_line.size() > 0);
    if (m_line.size() > 0) chk("tx_data", o_txd, m_line[0]);
    chk("fifo_level", o_lvl, lvl);
    chk("drop_cnt", o_drop, m_drop);
    if (o_txv && t_txr) cap.push_back(o_txd);

    idle = !m_loadp && m_line.size() == 0;
    if (m_line.size() > 0 && t_txr) void'(m_line.pop_front());
    if (m_loadp) begin
      render(m_held);
      m_loadp = 1'b0;
    end
    if (idle && lvl != 0) begin
      m_held  = m_fifo.pop_front();
      m_loadp = 1'b1;
    end
    if (push) begin
      e.ch   = g;
      e.pc   = t_pc[g];
      e.inst = t_inst[g];
      m_fifo.push_back(e);
      m_rr = (g + 1) % nch;
    end
    if (sel == 1) begin
      m_drop = m_drop + nv - (push ? 1 : 0);
      if (m_drop > 64'hffff_ffff) m_drop = 64'hffff_ffff;
    end
    @(negedge clk);
  endtask

  task automatic randomize_beats();
    for (int i = 0; i < 3; i++) begin
      t_pc[i]   = {$urandom, $urandom};
      t_inst[i] = $urandom;
    end
  endtask

  function automatic string cap_str();
    string s;
    s = "";
    foreach (cap[k]) s = {s, $sformatf("%c", cap[k])};
    return s;
  endfunction

  initial begin
    int         n;
    int         nacc;
    logic [7:0] exp_bin [13];
    rst     = 1'b1;
    sel     = 0;
    t_valid = 3'b011;
    t_txr   = 1'b0;
    randomize_beats();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_a_txv", a_txv, 1'b0);
    chk("rst_a_txd", a_txd, 8'h00);
    chk("rst_a_lvl", a_lvl, 5'd0);
    chk("rst_a_ready", a_ready, 2'b00);
    chk("rst_b_drop", b_drop, 32'd0);
    chk("rst_b_lvl", b_lvl, 5'd0);
    t_valid = 3'b000;
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Single hex line with latency measurement.
    t_txr     = 1'b1;
    t_valid   = 3'b001;
    t_pc[0]   = 64'h0000_0000_8000_0000;
    t_inst[0] = 32'h0000_0013;
    cap.delete();
    tick();
    t_valid = 3'b000;
    n = 0;
    while (n < 10) begin
      #1;
      if (a_txv) break;
      tick();
      n++;
    end
    chk("latency", n, 2);
    repeat (40) tick();
    chk("hex_len", cap.size(), 28);
    chk_str("hex_line", cap_str(), "0 0000000080000000 00000013\n");

    // Fill to full with the sink stalled, then drain.
    t_txr   = 1'b0;
    t_valid = 3'b011;
    nacc    = 0;
    repeat (25) begin
      randomize_beats();
      #1;
      if (a_ready != 2'b00) nacc++;
      tick();
    end
    chk("full_pushes", nacc, 17);
    chk("full_level", a_lvl, 5'd16);
    t_valid = 3'b000;
    t_txr   = 1'b1;
    repeat (17 * 30 + 20) tick();
    chk("drained_level", a_lvl, 5'd0);

    // Random beats against a randomly stalling sink.
    repeat (1500) begin
      randomize_beats();
      t_valid = 3'($urandom_range(0, 3));
      t_txr   = ($urandom % 4) != 0;
      tick();
    end
    t_valid = 3'b000;
    t_txr   = 1'b1;
    repeat (600) tick();

    // Reset in the middle of a line.
    t_valid = 3'b001;
    randomize_beats();
    tick();
    t_valid = 3'b010;
    tick();
    t_valid = 3'b000;
    cap.delete();
    n = 0;
    while (cap.size() < 7 && n < 60) begin
      tick();
      n++;
    end
    chk("pre_rst_bytes", cap.size(), 7);
    t_valid = 3'b011;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_txv", a_txv, 1'b0);
    chk("midrst_txd", a_txd, 8'h00);
    chk("midrst_lvl", a_lvl, 5'd0);
    chk("midrst_ready", a_ready, 2'b00);
    @(negedge clk);
    t_valid = 3'b000;
    rst     = 1'b0;
    model_reset();
    t_valid   = 3'b010;
    t_pc[1]   = 64'h0123_4567_89ab_cdef;
    t_inst[1] = 32'hcafe_f00d;
    tick();
    t_valid = 3'b000;
    cap.delete();
    repeat (40) tick();
    chk_str("post_rst_line", cap_str(), "1 0123456789abcdef cafef00d\n");

    // Binary records and drop accounting on the second instance.
    rst = 1'b1;
    @(negedge clk);
    sel = 1;
    rst = 1'b0;
    model_reset();
    t_txr     = 1'b1;
    t_valid   = 3'b010;
    t_pc[1]   = 64'h1122_3344_5566_7788;
    t_inst[1] = 32'hdead_beef;
    tick();
    t_valid = 3'b000;
    cap.delete();
    repeat (20) tick();
    exp_bin = '{8'h01, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11,
                8'hef, 8'hbe, 8'had, 8'hde};
    chk("bin_len", cap.size(), 13);
    for (int k = 0; k < 13 && k < cap.size(); k++) chk($sformatf("bin_byte%0d", k), cap[k], exp_bin[k]);

    t_txr   = 1'b0;
    t_valid = 3'b011;
    repeat (10) begin
      randomize_beats();
      tick();
    end
    chk("drop_after10", b_drop, 32'd10);
    chk("level_after10", b_lvl, 5'd9);
    repeat (7) begin
      randomize_beats();
      tick();
    end
    chk("level_full", b_lvl, 5'd16);
    chk("drop_at_full", b_drop, 32'd17);
    repeat (3) tick();
    chk("drop_full3", b_drop, 32'd23);
    t_valid = 3'b000;
    t_txr   = 1'b1;
    repeat (300) tick();

    repeat (1500) begin
      randomize_beats();
      t_valid = 3'($urandom_range(0, 7));
      t_txr   = ($urandom % 3) != 0;
      tick();
    end
    t_valid = 3'b000;
    t_txr   = 1'b1;
    repeat (400) tick();
    chk("final_level", b_lvl, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
